shift_arbiter: RTL and testbench

- Shares one 32-bit barrel shifter (SLL/SRL/SRA) between two requesters: requester 0 is the ALU issue path, requester 1 is the load/store byte-align path.
- Arbitrates with a round-robin pointer.
- Computes the shift in the grant cycle.
- Registers the result in a single-entry output buffer with a valid/ready handshake and a requester tag.

---
 rtl/shift_pkg.sv | 24 ++
 rtl/shift_core_32bit.sv | 39 +++
 rtl/shift_arbiter.sv | 114 +++++++++++
 tb/tb_shift_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types, widths and helpers for the shift arbiter slice.
package shift_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_RSV = 2'b11
    } shift_op_e;

    // Mirror a word end-to-end so a left shift can reuse the right-shift network.
    function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            r[i] = x[DATA_W-1-i];
        end
        return r;
    endfunction

endpackage : shift_pkg

// File: rtl/shift_core_32bit.sv
// Combinational 5-stage log shifter; left shifts run through the same
// right-shift stages on a bit-reversed operand.
module shift_core_32bit
    import shift_pkg::*;
(
    input  logic [DATA_W-1:0]  i_data,
    input  logic [SHAMT_W-1:0] i_shamt,
    input  shift_op_e          i_op,
    output logic [DATA_W-1:0]  o_result
);

    logic                           is_left;
    logic                           fill;
    logic [SHAMT_W:0][DATA_W-1:0]   stg;

    // Direction and fill bit: only SRA replicates the sign bit.
    always_comb begin
        is_left = (i_op == SH_SLL);
        fill    = (i_op == SH_SRA) & i_data[DATA_W-1];
        stg[0]  = is_left ? bit_rev(i_data) : i_data;
    end

    // One mux stage per shamt bit: shift by 1, 2, 4, 8, 16.
    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        localparam int unsigned SH = 1 << k;
        assign stg[k+1] = i_shamt[k] ? {{SH{fill}}, stg[k][DATA_W-1:SH]} : stg[k];
    end

    // Undo the reversal for left shifts; reserved op passes the operand through.
    always_comb begin
        o_result = stg[SHAMT_W];
        if (i_op == SH_RSV) begin
            o_result = i_data;
        end else if (is_left) begin
            o_result = bit_rev(stg[SHAMT_W]);
        end
    end

endmodule : shift_core_32bit

// File: rtl/shift_arbiter.sv
// Two-requester arbiter in front of a shared barrel shifter with a
// single-entry registered result buffer (valid/ready, requester tag).
module shift_arbiter #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SHAMT_W = 5,
    parameter bit          RR_EN   = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [1:0]         i_req_valid,
    output logic [1:0]         o_req_ready,
    input  logic [DATA_W-1:0]  i_req0_data,
    input  logic [SHAMT_W-1:0] i_req0_shamt,
    input  logic [1:0]         i_req0_op,
    input  logic [DATA_W-1:0]  i_req1_data,
    input  logic [SHAMT_W-1:0] i_req1_shamt,
    input  logic [1:0]         i_req1_op,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [DATA_W-1:0]  o_out_data,
    output logic               o_out_tag,
    output logic               o_out_err
);

    import shift_pkg::*;

    logic               accept_en;
    logic               gnt;
    logic               gnt_any;
    logic               xfer;
    logic [DATA_W-1:0]  sel_data;
    logic [SHAMT_W-1:0] sel_shamt;
    shift_op_e          sel_op;
    logic [DATA_W-1:0]  shift_res;

    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q,  out_data_d;
    logic               out_tag_q,   out_tag_d;
    logic               out_err_q,   out_err_d;
    logic               rr_ptr_q,    rr_ptr_d;

    // Grant selection: the pointer only breaks ties when both requesters are valid.
    always_comb begin
        accept_en = !out_valid_q || i_out_ready;
        gnt_any   = |i_req_valid;
        gnt       = 1'b0;
        case (i_req_valid)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = RR_EN ? rr_ptr_q : 1'b0;
            default: gnt = 1'b0;
        endcase
        xfer        = accept_en && gnt_any;
        o_req_ready = 2'b00;
        if (xfer) begin
            o_req_ready = gnt ? 2'b10 : 2'b01;
        end
    end

    // Operand mux feeding the shared shifter.
    always_comb begin
        sel_data  = gnt ? i_req1_data  : i_req0_data;
        sel_shamt = gnt ? i_req1_shamt : i_req0_shamt;
        sel_op    = shift_op_e'(gnt ? i_req1_op : i_req0_op);
    end

    shift_core_32bit u_core (
        .i_data   (sel_data),
        .i_shamt  (sel_shamt),
        .i_op     (sel_op),
        .o_result (shift_res)
    );

    // Buffer and pointer update: load on transfer, clear valid on a pure drain.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        out_err_d   = out_err_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = shift_res;
            out_tag_d   = gnt;
            out_err_d   = (sel_op == SH_RSV);
            rr_ptr_d    = ~gnt;
        end else if (i_out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset discards any buffered result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= 1'b0;
            out_err_q   <= 1'b0;
            rr_ptr_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            out_err_q   <= out_err_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign o_out_valid = out_valid_q;
    assign o_out_data  = out_data_q;
    assign o_out_tag   = out_tag_q;
    assign o_out_err   = out_err_q;

endmodule : shift_arbiter

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: round-robin instance plus a fixed-priority
// instance sharing the same stimulus.
`timescale 1ns/1ps
module tb_shift_arbiter;

    logic        i_clk;
    logic        i_rst_n;
    logic [1:0]  i_req_valid;
    logic [31:0] i_req0_data;
    logic [4:0]  i_req0_shamt;
    logic [1:0]  i_req0_op;
    logic [31:0] i_req1_data;
    logic [4:0]  i_req1_shamt;
    logic [1:0]  i_req1_op;
    logic        i_out_ready;

    logic [1:0]  rr_req_ready;
    logic        rr_out_valid;
    logic [31:0] rr_out_data;
    logic        rr_out_tag;
    logic        rr_out_err;

    logic [1:0]  fp_req_ready;
    logic        fp_out_valid;
    logic [31:0] fp_out_data;
    logic        fp_out_tag;
    logic        fp_out_err;

    int n_checks;
    int n_fail;

    shift_arbiter #(.DATA_W(32), .SHAMT_W(5), .RR_EN(1'b1)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (rr_req_ready),
        .i_req0_data  (i_req0_data),
        .i_req0_shamt (i_req0_shamt),
        .i_req0_op    (i_req0_op),
        .i_req1_data  (i_req1_data),
        .i_req1_shamt (i_req1_shamt),
        .i_req1_op    (i_req1_op),
        .o_out_valid  (rr_out_valid),
        .i_out_ready  (i_out_ready),
        .o_out_data   (rr_out_data),
        .o_out_tag    (rr_out_tag),
        .o_out_err    (rr_out_err)
    );

    shift_arbiter #(.DATA_W(32), .SHAMT_W(5), .RR_EN(1'b0)) dut_fp (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (fp_req_ready),
        .i_req0_data  (i_req0_data),
        .i_req0_shamt (i_req0_shamt),
        .i_req0_op    (i_req0_op),
        .i_req1_data  (i_req1_data),
        .i_req1_shamt (i_req1_shamt),
        .i_req1_op    (i_req1_op),
        .o_out_valid  (fp_out_valid),
        .i_out_ready  (i_out_ready),
        .o_out_data   (fp_out_data),
        .o_out_tag    (fp_out_tag),
        .o_out_err    (fp_out_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req0(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
        i_req0_data  = d;
        i_req0_shamt = s;
        i_req0_op    = op;
    endtask

    task automatic set_req1(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
        i_req1_data  = d;
        i_req1_shamt = s;
        i_req1_op    = op;
    endtask

    logic [31:0] tv_data  [5];
    logic [4:0]  tv_shamt [5];
    logic [1:0]  tv_op    [5];
    logic [31:0] tv_exp   [5];

    initial begin
        n_checks = 0;
        n_fail   = 0;

        tv_data[0] = 32'h8000_0000; tv_shamt[0] = 5'd31; tv_op[0] = 2'b10; tv_exp[0] = 32'hFFFF_FFFF;
        tv_data[1] = 32'h7FFF_FFFF; tv_shamt[1] = 5'd31; tv_op[1] = 2'b10; tv_exp[1] = 32'h0000_0000;
        tv_data[2] = 32'hA5A5_A5A5; tv_shamt[2] = 5'd0;  tv_op[2] = 2'b00; tv_exp[2] = 32'hA5A5_A5A5;
        tv_data[3] = 32'h8000_0000; tv_shamt[3] = 5'd31; tv_op[3] = 2'b01; tv_exp[3] = 32'h0000_0001;
        tv_data[4] = 32'h0000_FFFF; tv_shamt[4] = 5'd8;  tv_op[4] = 2'b00; tv_exp[4] = 32'h00FF_FF00;

        // Reset state
        i_rst_n     = 1'b0;
        i_req_valid = 2'b00;
        i_out_ready = 1'b0;
        set_req0(32'h0, 5'd0, 2'b00);
        set_req1(32'h0, 5'd0, 2'b00);
        #3;
        chk("rst_valid", 32'(rr_out_valid), 32'd0);
        chk("rst_data",  rr_out_data,       32'd0);
        chk("rst_tag",   32'(rr_out_tag),   32'd0);
        chk("rst_err",   32'(rr_out_err),   32'd0);
        chk("rst_ready", 32'(rr_req_ready), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Single request: SRA 0x80000001 by 4
        @(negedge i_clk);
        i_out_ready = 1'b1;
        i_req_valid = 2'b01;
        set_req0(32'h8000_0001, 5'd4, 2'b10);
        #1;
        chk("single_ready", 32'(rr_req_ready), 32'd1);
        @(negedge i_clk);
        chk("single_valid", 32'(rr_out_valid), 32'd1);
        chk("single_data",  rr_out_data,       32'hF800_0000);
        chk("single_tag",   32'(rr_out_tag),   32'd0);
        chk("single_err",   32'(rr_out_err),   32'd0);
        i_req_valid = 2'b00;
        @(negedge i_clk);
        chk("drain_valid", 32'(rr_out_valid), 32'd0);
        chk("drain_hold",  rr_out_data,       32'hF800_0000);

        // Reserved op from requester 1
        i_req_valid = 2'b10;
        set_req1(32'h1234_5678, 5'd7, 2'b11);
        #1;
        chk("rsv_ready", 32'(rr_req_ready), 32'd2);
        @(negedge i_clk);
        chk("rsv_data", rr_out_data,     32'h1234_5678);
        chk("rsv_err",  32'(rr_out_err), 32'd1);
        chk("rsv_tag",  32'(rr_out_tag), 32'd1);

        // Contention: pointer is back at 0, grants alternate 0,1,0,1
        i_req_valid = 2'b11;
        set_req0(32'h0000_0001, 5'd31, 2'b00);
        set_req1(32'hFFFF_FFFF, 5'd28, 2'b01);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("cont_ready", 32'(rr_req_ready), (i % 2 == 0) ? 32'd1 : 32'd2);
            @(negedge i_clk);
            chk("cont_valid", 32'(rr_out_valid), 32'd1);
            chk("cont_tag",   32'(rr_out_tag),   32'(i % 2));
            chk("cont_data",  rr_out_data,       (i % 2 == 0) ? 32'h8000_0000 : 32'h0000_000F);
            chk("cont_err",   32'(rr_out_err),   32'd0);
        end

        // Backpressure: three stalled cycles with both requests pending
        i_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", 32'(rr_req_ready), 32'd0);
            chk("bp_valid", 32'(rr_out_valid), 32'd1);
            chk("bp_data",  rr_out_data,       32'h0000_000F);
            chk("bp_tag",   32'(rr_out_tag),   32'd1);
            @(negedge i_clk);
        end
        i_out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(rr_req_ready), 32'd1);
        @(negedge i_clk);
        chk("bp_nobubble_valid", 32'(rr_out_valid), 32'd1);
        chk("bp_nobubble_data",  rr_out_data,       32'h8000_0000);
        chk("bp_nobubble_tag",   32'(rr_out_tag),   32'd0);

        // Shift boundaries through requester 0 alone
        i_req_valid = 2'b01;
        for (int i = 0; i < 5; i++) begin
            set_req0(tv_data[i], tv_shamt[i], tv_op[i]);
            #1;
            chk("tv_ready", 32'(rr_req_ready), 32'd1);
            @(negedge i_clk);
            chk("tv_data", rr_out_data,     tv_exp[i]);
            chk("tv_err",  32'(rr_out_err), 32'd0);
        end

        // Reset mid-operation while stalled; pointer is 1 at this point
        i_req_valid = 2'b00;
        i_out_ready = 1'b0;
        @(negedge i_clk);
        chk("stall_valid", 32'(rr_out_valid), 32'd1);
        i_rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(rr_out_valid), 32'd0);
        chk("midrst_data",  rr_out_data,       32'd0);
        @(negedge i_clk);
        i_rst_n     = 1'b1;
        i_out_ready = 1'b1;
        i_req_valid = 2'b11;
        set_req0(32'h0000_00F0, 5'd4, 2'b01);
        set_req1(32'h0000_0003, 5'd2, 2'b00);
        #1;
        chk("postrst_ready", 32'(rr_req_ready), 32'd1);

        // Fixed-priority instance: requester 0 every cycle
        for (int i = 0; i < 4; i++) begin
            if (i > 0) #1;
            chk("fp_ready", 32'(fp_req_ready), 32'd1);
            @(negedge i_clk);
            chk("fp_tag",  32'(fp_out_tag),  32'd0);
            chk("fp_data", fp_out_data,      32'h0000_000F);
            chk("rr_tag",  32'(rr_out_tag),  32'(i % 2));
            chk("rr_data", rr_out_data,      (i % 2 == 0) ? 32'h0000_000F : 32'h0000_000C);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_shift_arbiter
